// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer
// Top-level game controller for the snake datapath. It contains the master FSM
// (IDLE/PLAY/WIN/LOSE), game-tick enable generation, the direction register fed by
// the buttons, the score, and the no-eat timeout.
//
// Optional feature macro: SNAKE_SPEEDUP_EN
//   defined   : tick period = TICK_DIV - SCORE*(TICK_DIV/16), floored at TICK_DIV/4,
//               reloaded at each counter wrap and reset to TICK_DIV on PLAY entry
//   undefined : tick period fixed at TICK_DIV
//
// Ports
//   CLK               in   system clock
//   RESET             in   synchronous, active-high reset
//   BTN_U/D/L/R       in   debounced, CLK-synchronous button levels
//   REACHED_TARGET    in   snake head on apple (level)
//   MASTER_STATE      out  0=IDLE 1=PLAY 2=WIN 3=LOSE
//   NAVIGATION_STATE  out  00=right 01=down 10=up 11=left
//   GAME_TICK         out  one-cycle step enable for the datapath
//   APPLE_RESPAWN     out  one-cycle request to latch a new apple position
//   SCORE             out  apples eaten this game (saturating at 255)
module snake_game_sequencer #(
  parameter int unsigned TICK_DIV      = 5000000,
  parameter int unsigned WIN_SCORE     = 10,
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       REACHED_TARGET,
  output logic [1:0] MASTER_STATE,
  output logic [1:0] NAVIGATION_STATE,
  output logic       GAME_TICK,
  output logic       APPLE_RESPAWN,
  output logic [7:0] SCORE
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0]  DIR_RIGHT   = 2'b00;
  localparam logic [1:0]  DIR_DOWN    = 2'b01;
  localparam logic [1:0]  DIR_UP      = 2'b10;
  localparam logic [1:0]  DIR_LEFT    = 2'b11;
  localparam logic [7:0]  WIN_SCORE_B = 8'(WIN_SCORE);
  localparam logic [15:0] TIMEOUT_B   = 16'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      nav_q, nav_d;
  logic [1:0]      pend_q, pend_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic [7:0]      score_q, score_d;
  logic            first_q, first_d;
  logic [3:0]      btn_prev_q;
  logic            tgt_prev_q;

  logic [3:0]      btn_now;
  logic [3:0]      press;
  logic            any_press;
  logic            eat_edge;
  logic            in_play;
  logic            tick;
  logic            eat;
  logic [1:0]      req_dir;
  logic            accept;
  logic [15:0]     to_inc;
  logic [CW-1:0]   tick_last;

`ifdef SNAKE_SPEEDUP_EN
  localparam int unsigned PW       = CW + 1;
  localparam int unsigned PER_MIN  = TICK_DIV / 4;
  localparam int unsigned PER_STEP = TICK_DIV / 16;

  logic [PW-1:0]   period_q, period_d;
  logic [PW-1:0]   period_next;
  int unsigned     reduction;

  // Shorten the period by one step per apple, never below a quarter period.
  always_comb begin
    reduction   = 32'(score_q) * PER_STEP;
    period_next = PW'(TICK_DIV - reduction);
    if (reduction > (TICK_DIV - PER_MIN)) begin
      period_next = PW'(PER_MIN);
    end
  end

  assign tick_last = CW'(period_q - PW'(1));
`else
  assign tick_last = CW'(TICK_DIV - 1);
`endif

  assign btn_now   = {BTN_U, BTN_D, BTN_L, BTN_R};
  assign press     = btn_now & ~btn_prev_q;
  assign any_press = |press;
  assign eat_edge  = REACHED_TARGET & ~tgt_prev_q;
  assign in_play   = (state_q == ST_PLAY);
  assign tick      = in_play && (tick_cnt_q == tick_last);
  assign eat       = in_play && eat_edge;
  assign to_inc    = to_cnt_q + 16'd1;

  // Highest-priority press wins first; it is then dropped if it would reverse
  // the snake onto itself (opposite directions are bitwise complements).
  always_comb begin
    req_dir = DIR_RIGHT;
    if (press[3])      req_dir = DIR_UP;
    else if (press[2]) req_dir = DIR_DOWN;
    else if (press[1]) req_dir = DIR_LEFT;
    accept = in_play && any_press && (req_dir != ~nav_q);
  end

  always_comb begin
    state_d    = state_q;
    nav_d      = nav_q;
    pend_d     = pend_q;
    tick_cnt_d = '0;
    to_cnt_d   = to_cnt_q;
    score_d    = score_q;
    first_d    = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    period_d   = period_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d  = ST_PLAY;
          score_d  = '0;
          nav_d    = DIR_RIGHT;
          pend_d   = DIR_RIGHT;
          to_cnt_d = '0;
          first_d  = 1'b1;
`ifdef SNAKE_SPEEDUP_EN
          period_d = PW'(TICK_DIV);
`endif
        end
      end
      ST_PLAY: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
        if (accept) pend_d = req_dir;
        if (tick) begin
          nav_d    = pend_q;
          to_cnt_d = to_inc;
`ifdef SNAKE_SPEEDUP_EN
          period_d = period_next;
`endif
        end
        // Eating clears the timeout even on a tick cycle, so the win check
        // naturally takes precedence over the timeout check.
        if (eat) begin
          score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          to_cnt_d = '0;
          if (score_d >= WIN_SCORE_B) state_d = ST_WIN;
        end else if (tick && (to_inc >= TIMEOUT_B)) begin
          state_d = ST_LOSE;
        end
        if (state_d != ST_PLAY) tick_cnt_d = '0;
      end
      ST_WIN, ST_LOSE: begin
        if (any_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      nav_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      tick_cnt_q <= '0;
      to_cnt_q   <= '0;
      score_q    <= '0;
      first_q    <= 1'b0;
      btn_prev_q <= '0;
      tgt_prev_q <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      period_q   <= PW'(TICK_DIV);
`endif
    end else begin
      state_q    <= state_d;
      nav_q      <= nav_d;
      pend_q     <= pend_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      score_q    <= score_d;
      first_q    <= first_d;
      btn_prev_q <= btn_now;
      tgt_prev_q <= REACHED_TARGET;
`ifdef SNAKE_SPEEDUP_EN
      period_q   <= period_d;
`endif
    end
  end

  // Pulses are combinational so they land in the cycle of the event; masking
  // with RESET keeps the reset cycle pulse-free.
  assign MASTER_STATE     = state_q;
  assign NAVIGATION_STATE = nav_q;
  assign SCORE            = score_q;
  assign GAME_TICK        = tick & ~RESET;
  assign APPLE_RESPAWN    = in_play & (first_q | eat_edge) & ~RESET;

endmodule
